// File: rtl/montgomery_mul.sv
// Bit-serial radix-2 Montgomery multiplier over GF(2^255-19): o_result = a*b*2^-ITER mod N.
// Optional MONTMUL_TO_MONT_EN adds i_to_mont, which swaps i_b for R^2 mod N (to-Montgomery conversion).
module montgomery_mul #(
    parameter int               WIDTH = 255,
    parameter logic [WIDTH-1:0] N     = 255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed,
    parameter int               ITER  = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
`ifdef MONTMUL_TO_MONT_EN
    input  logic             i_to_mont,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_finished,
    output logic             o_busy
);

    localparam int SW = WIDTH + 2;
    localparam int CW = $clog2(ITER);

`ifdef MONTMUL_TO_MONT_EN
    // 2^256 mod (2^255-19) = 38, so R^2 mod N = 38^2.
    localparam logic [WIDTH-1:0] R2_MOD_N = WIDTH'(1444);
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOOP, S_FINAL} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [SW-1:0]     s_q;
    logic [CW-1:0]     cnt;

    logic [SW-1:0]     t0;
    logic [SW-1:0]     t1;
    logic              borrow;
    logic              d_unused;
    logic [WIDTH-1:0]  d;

    // S < 2N and B, N < 2^255, so every intermediate stays below 4N < 2^SW.
    always_comb begin
        t0 = s_q + (a_q[0] ? {2'b00, b_q} : '0);
        t1 = t0 + (t0[0] ? {2'b00, N} : '0);
        {borrow, d_unused, d} = s_q - {2'b00, N};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            s_q        <= '0;
            cnt        <= '0;
            o_result   <= '0;
            o_finished <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        a_q    <= i_a;
`ifdef MONTMUL_TO_MONT_EN
                        b_q    <= i_to_mont ? R2_MOD_N : i_b;
`else
                        b_q    <= i_b;
`endif
                        s_q    <= '0;
                        cnt    <= '0;
                        o_busy <= 1'b1;
                        state  <= S_LOOP;
                    end
                end
                S_LOOP: begin
                    s_q <= t1 >> 1;
                    a_q <= a_q >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1))
                        state <= S_FINAL;
                end
                S_FINAL: begin
                    // S < 2N: a single conditional subtraction fully reduces.
                    o_result   <= borrow ? s_q[WIDTH-1:0] : d;
                    o_finished <= 1'b1;
                    o_busy     <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_montgomery_mul.sv
// Directed + random bench for montgomery_mul against a big-integer model (a*b*R^-1 mod N).
module tb_montgomery_mul;

    localparam logic [254:0] NP = 255'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffed;
    localparam int LAT = 257;  // sampling edge counts as the first of 258 edges

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic         to_mont = 1'b0;
    logic [254:0] i_a = '0;
    logic [254:0] i_b = '0;
    logic [254:0] o_result;
    logic         o_finished;
    logic         o_busy;

    montgomery_mul dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
`ifdef MONTMUL_TO_MONT_EN
        .i_to_mont  (to_mont),
`endif
        .i_a        (i_a),
        .i_b        (i_b),
        .o_result   (o_result),
        .o_finished (o_finished),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [254:0] res;
        int           fin_cyc;
    } exp_t;
    exp_t q[$];
    logic [254:0] last_res = '0;
    logic [511:0] rinv;

    task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [254:0] mont_ref(input logic [254:0] a, input logic [254:0] b);
        logic [511:0] p;
        p = ({257'b0, a} * {257'b0, b}) % {257'b0, NP};
        p = (p * rinv) % {257'b0, NP};
        return p[254:0];
    endfunction

    function automatic logic [254:0] rand_fe();
        logic [511:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[479:0], 32'($urandom())};
        r = r % {257'b0, NP};
        return r[254:0];
    endfunction

    // Compare process: every cycle checks handshake, latency, hold and result.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            chk("rst_result", o_result, '0);
            chk("rst_finished", 255'(o_finished), '0);
            chk("rst_busy", 255'(o_busy), '0);
        end else if (o_finished) begin
            if (q.size() == 0) begin
                chk("spurious_finish", 255'(o_finished), '0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("latency", 255'(cyc), 255'(e.fin_cyc));
                chk("result", o_result, e.res);
                chk("busy_at_finish", 255'(o_busy), '0);
                last_res = e.res;
            end
        end else begin
            chk("busy", 255'(o_busy), 255'(q.size() != 0));
            chk("result_hold", o_result, last_res);
        end
    end

    task automatic start_op(input logic [254:0] a, input logic [254:0] b, input logic tm);
        exp_t e;
        int   n;
        i_a = a; i_b = b; to_mont = tm; i_start = 1'b1;
        n = cyc + 1;
        e.res = tm ? mont_ref(a, 255'd1444) : mont_ref(a, b);
        e.fin_cyc = n + LAT;
        @(posedge i_clk);
        q.push_back(e);
        #1 i_start = 1'b0;
    endtask

    // Returns in the o_finished cycle so the next start is back-to-back.
    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            #1;
            if (q.size() == 0) return;
        end
        chk("timeout", 255'(q.size()), '0);
        q.delete();
    endtask

    task automatic run(input logic [254:0] a, input logic [254:0] b, input logic tm);
        start_op(a, b, tm);
        wait_done();
    endtask

    initial begin
        logic [511:0] half;
        logic [511:0] x;
        int           fin;
        half = ({257'b0, NP} + 512'd1) >> 1;
        rinv = 512'd1;
        repeat (256) rinv = (rinv * half) % {257'b0, NP};

        // Pin the model with hand-derived values (R mod N = 38).
        x = (rinv * 512'd38) % {257'b0, NP};
        chk("model_rinv", x[254:0], 255'd1);
        chk("model_identity", mont_ref(255'd38, 255'd12345), 255'd12345);
        chk("model_self", mont_ref(255'd38, 255'd38), 255'd38);
        chk("model_zero", mont_ref(255'd0, NP - 255'd1), 255'd0);
        chk("model_nm1", mont_ref(255'd38, NP - 255'd1), NP - 255'd1);
        chk("model_tomont", mont_ref(255'd2, 255'd1444), 255'd76);

        repeat (3) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        #1;

        run(255'd38, 255'd12345, 1'b0);
        chk("identity_lit", o_result, 255'd12345);
        run(255'd0, NP - 255'd1, 1'b0);
        chk("zero_lit", o_result, 255'd0);
        run(255'd38, NP - 255'd1, 1'b0);
        chk("b2b_nm1_lit", o_result, NP - 255'd1);
        run(255'd38, 255'd38, 1'b0);
        chk("self_lit", o_result, 255'd38);
        run(NP - 255'd1, 255'd0, 1'b0);
        run(NP - 255'd1, NP - 255'd1, 1'b0);
        run(255'd1, 255'd1, 1'b0);

        // Starts while busy, including one sampled on the finishing edge, are ignored.
        start_op(255'd1234, 255'd5678, 1'b0);
        fin = q[0].fin_cyc;
        repeat (50) @(posedge i_clk);
        #2 i_a = 255'd999; i_b = 255'd777; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge i_clk);
            #2;
            if (cyc >= fin - 1) break;
        end
        i_a = 255'd4242; i_b = 255'd4343; i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
        wait_done();
        repeat (3) @(negedge i_clk);

        // Reset mid-run: outputs clear at once and the pending result never appears.
        start_op(255'd777, 255'd888, 1'b0);
        repeat (100) @(posedge i_clk);
        #2 i_rst_n = 1'b0;
        q.delete();
        last_res = '0;
        #1;
        chk("async_rst_result", o_result, '0);
        chk("async_rst_finished", 255'(o_finished), '0);
        chk("async_rst_busy", 255'(o_busy), '0);
        repeat (2) @(posedge i_clk);
        #2 i_rst_n = 1'b1;
        repeat (300) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        run(255'd38, 255'd12345, 1'b0);
        chk("post_rst_lit", o_result, 255'd12345);

        for (int i = 0; i < 30; i++) run(rand_fe(), rand_fe(), 1'b0);

`ifdef MONTMUL_TO_MONT_EN
        run(255'd1, 255'd5, 1'b1);
        chk("tomont_1_lit", o_result, 255'd38);
        run(255'd2, 255'd5, 1'b1);
        chk("tomont_2_lit", o_result, 255'd76);
        run(255'd38, 255'd12345, 1'b0);
        chk("tomont_off_lit", o_result, 255'd12345);
        for (int i = 0; i < 5; i++) run(rand_fe(), rand_fe(), 1'b1);
`endif

        repeat (3) @(negedge i_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
